// File: rtl/fp_round_pack.sv
// Two-stage round-and-pack for the 12-bit linear-to-float converter.
// Extracts a 4-bit significand, rounds half-up, renormalises or saturates.
module fp_round_pack #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [11:0]      in_mag,
  input  logic [2:0]       in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [2:0]       out_exp,
  output logic [3:0]       out_frac,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_count
);

  logic             s1_valid_q;
  logic             s1_sign_q;
  logic [2:0]       s1_exp_q;
  logic [3:0]       s1_frac_q;
  logic             s1_r_q;
  logic             s1_sat_q;

  logic             s2_valid_q;
  logic             s2_sign_q;
  logic [2:0]       s2_exp_q;
  logic [3:0]       s2_frac_q;
  logic [CNT_W-1:0] cnt_q;

  logic             s1_adv;
  logic             s2_adv;
  logic [12:0]      sh;
  logic [4:0]       sum;
  logic [2:0]       s2_exp_d;
  logic [3:0]       s2_frac_d;
  logic             sat_d;
  logic             cnt_inc;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Bit 0 of the shifted word is the round bit; zero when in_exp is 0.
  assign sh = {in_mag, 1'b0} >> in_exp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_frac_q  <= '0;
      s1_r_q     <= 1'b0;
      s1_sat_q   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= in_sign;
        s1_exp_q  <= in_exp;
        s1_frac_q <= sh[4:1];
        s1_r_q    <= sh[0];
        s1_sat_q  <= in_mag[11];
      end
    end
  end

  always_comb begin
    sum       = {1'b0, s1_frac_q} + {4'b0, s1_r_q};
    sat_d     = 1'b0;
    s2_exp_d  = s1_exp_q;
    s2_frac_d = sum[3:0];
    if (s1_sat_q || (sum[4] && s1_exp_q == 3'd7)) begin
      sat_d     = 1'b1;
      s2_exp_d  = 3'd7;
      s2_frac_d = 4'hF;
    end else if (sum[4]) begin
      s2_exp_d  = s1_exp_q + 3'd1;
      s2_frac_d = 4'h8;
    end
  end

  assign cnt_inc = s2_adv && s1_valid_q && sat_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_frac_q  <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_q <= s1_sign_q;
        s2_exp_q  <= s2_exp_d;
        s2_frac_q <= s2_frac_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (sat_clr) begin
      cnt_q <= {{(CNT_W-1){1'b0}}, cnt_inc};
    end else if (cnt_inc && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sign  = s2_sign_q;
  assign out_exp   = s2_exp_q;
  assign out_frac  = s2_frac_q;
  assign sat_count = cnt_q;

endmodule
